// File: rtl/pmips_pkg.sv
// Shared constants and types for the pmips fetch front end.
// Holds word width, reset PC default, PC step and FSM state encoding.
package pmips_pkg;

    localparam int          WORD_W       = 16;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;
    localparam logic [15:0] PC_STEP      = 16'd2;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/ifetch_pc.sv
// Program counter register: redirect beats increment beats hold.
// Ports: clock, reset_n, i_redirect, i_target, i_inc, o_pc.
module ifetch_pc
    import pmips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_redirect,
    input  logic [WORD_W-1:0] i_target,
    input  logic              i_inc,
    output logic [WORD_W-1:0] o_pc
);

    logic [WORD_W-1:0] r_pc;

    // Increment wraps naturally at 16 bits (FFFE -> 0000).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= RESET_PC;
        end else if (i_redirect) begin
            r_pc <= i_target;
        end else if (i_inc) begin
            r_pc <= r_pc + PC_STEP;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller with RUN/HALT FSM and valid/ready output.
// Ports: clock, reset_n, iaddr/idata (memory), inst/inst_pc/inst_valid/
// inst_ready (decode), br_taken/br_target, halt/halted, fetch_count.
module ifetch_ctrl
    import pmips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic [WORD_W-1:0] iaddr,
    input  logic [WORD_W-1:0] idata,
    output logic [WORD_W-1:0] inst,
    output logic [WORD_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              br_taken,
    input  logic [WORD_W-1:0] br_target,
    input  logic              halt,
    output logic              halted,
    output logic [WORD_W-1:0] fetch_count
);

    fetch_state_t      r_state;
    logic [WORD_W-1:0] r_inst;
    logic [WORD_W-1:0] r_inst_pc;
    logic              r_valid;
    logic [WORD_W-1:0] r_count;

    logic [WORD_W-1:0] w_pc;
    logic [WORD_W-1:0] w_target;
    logic              w_xfer;
    logic              w_fetch;

    // Redirect targets are forced halfword aligned.
    assign w_target = br_target & ~16'h0001;
    assign w_xfer   = r_valid & inst_ready;
    assign w_fetch  = (r_state == ST_RUN) & ~br_taken & ~halt
                    & (~r_valid | inst_ready);

    ifetch_pc #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_redirect (br_taken),
        .i_target   (w_target),
        .i_inc      (w_fetch),
        .o_pc       (w_pc)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_RUN;
            r_inst    <= '0;
            r_inst_pc <= '0;
            r_valid   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (br_taken) begin
                        r_valid <= 1'b0;
                    end else if (halt) begin
                        // Held inst survives until decode takes it.
                        r_state <= ST_HALT;
                        if (w_xfer) r_valid <= 1'b0;
                    end else if (w_fetch) begin
                        r_inst    <= idata;
                        r_inst_pc <= w_pc;
                        r_valid   <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (br_taken) begin
                        r_valid <= 1'b0;
                    end else begin
                        if (w_xfer) r_valid <= 1'b0;
                        if (!halt)  r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // Counts every handshake, including one coincident with a redirect.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (w_xfer && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign iaddr       = w_pc;
    assign inst        = r_inst;
    assign inst_pc     = r_inst_pc;
    assign inst_valid  = r_valid;
    assign halted      = (r_state == ST_HALT);
    assign fetch_count = r_count;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed self-checking bench for ifetch_ctrl.
// Memory model returns 16'h6103 at 0, else address ^ 16'h5A00.
module tb_ifetch_ctrl;

    logic        clock;
    logic        reset_n;
    logic [15:0] iaddr;
    logic [15:0] idata;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        br_taken;
    logic [15:0] br_target;
    logic        halt;
    logic        halted;
    logic [15:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    function automatic logic [15:0] mem(input logic [15:0] a);
        return (a == 16'h0000) ? 16'h6103 : (a ^ 16'h5A00);
    endfunction

    assign idata = mem(iaddr);

    ifetch_ctrl #(.RESET_PC(16'h0000)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .iaddr       (iaddr),
        .idata       (idata),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .halt        (halt),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag,
                           input logic [15:0] e_iaddr,
                           input logic [15:0] e_inst,
                           input logic [15:0] e_pc,
                           input logic        e_valid,
                           input logic        e_halted,
                           input logic [15:0] e_cnt);
        chk({tag, ".iaddr"},   iaddr,              e_iaddr);
        chk({tag, ".inst"},    inst,               e_inst);
        chk({tag, ".inst_pc"}, inst_pc,            e_pc);
        chk({tag, ".valid"},   {15'd0, inst_valid}, {15'd0, e_valid});
        chk({tag, ".halted"},  {15'd0, halted},     {15'd0, e_halted});
        chk({tag, ".count"},   fetch_count,        e_cnt);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b1;
        inst_ready = 1'b0;
        br_taken   = 1'b0;
        br_target  = 16'h0000;
        halt       = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        chk_all("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd0);

        step();
        reset_n    = 1'b1;
        inst_ready = 1'b1;

        step();
        chk_all("first", 16'h0002, 16'h6103, 16'h0000, 1'b1, 1'b0, 16'd0);
        step();
        chk_all("seq2", 16'h0004, mem(16'h0002), 16'h0002, 1'b1, 1'b0, 16'd1);
        step();
        chk_all("seq4", 16'h0006, mem(16'h0004), 16'h0004, 1'b1, 1'b0, 16'd2);

        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("stall", 16'h0006, mem(16'h0004), 16'h0004,
                    1'b1, 1'b0, 16'd2);
        end
        inst_ready = 1'b1;
        step();
        chk_all("unstall", 16'h0008, mem(16'h0006), 16'h0006,
                1'b1, 1'b0, 16'd3);

        inst_ready = 1'b0;
        br_taken   = 1'b1;
        br_target  = 16'h0005;
        step();
        chk_all("br_stall", 16'h0004, mem(16'h0006), 16'h0006,
                1'b0, 1'b0, 16'd3);
        br_taken   = 1'b0;
        inst_ready = 1'b1;
        step();
        chk_all("br_fetch", 16'h0006, mem(16'h0004), 16'h0004,
                1'b1, 1'b0, 16'd3);

        br_taken  = 1'b1;
        br_target = 16'hFFFE;
        step();
        chk_all("br_xfer", 16'hFFFE, mem(16'h0004), 16'h0004,
                1'b0, 1'b0, 16'd4);
        br_taken = 1'b0;
        step();
        chk_all("top", 16'h0000, mem(16'hFFFE), 16'hFFFE,
                1'b1, 1'b0, 16'd4);
        step();
        chk_all("wrap", 16'h0002, 16'h6103, 16'h0000, 1'b1, 1'b0, 16'd5);

        inst_ready = 1'b0;
        halt       = 1'b1;
        step();
        chk_all("halt1", 16'h0002, 16'h6103, 16'h0000, 1'b1, 1'b1, 16'd5);
        step();
        chk_all("halt2", 16'h0002, 16'h6103, 16'h0000, 1'b1, 1'b1, 16'd5);
        inst_ready = 1'b1;
        step();
        chk_all("halt_acc", 16'h0002, 16'h6103, 16'h0000, 1'b0, 1'b1, 16'd6);
        step();
        chk_all("halt_idle", 16'h0002, 16'h6103, 16'h0000, 1'b0, 1'b1, 16'd6);
        halt = 1'b0;
        step();
        chk_all("resume", 16'h0002, 16'h6103, 16'h0000, 1'b0, 1'b0, 16'd6);
        step();
        chk_all("res_fetch", 16'h0004, mem(16'h0002), 16'h0002,
                1'b1, 1'b0, 16'd6);
        step();
        chk_all("res_acc", 16'h0006, mem(16'h0004), 16'h0004,
                1'b1, 1'b0, 16'd7);

        inst_ready = 1'b0;
        step();
        chk_all("pre_rst", 16'h0006, mem(16'h0004), 16'h0004,
                1'b1, 1'b0, 16'd7);
        #2;
        reset_n   = 1'b0;
        br_taken  = 1'b1;
        br_target = 16'h1234;
        #1;
        chk_all("async_rst", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd0);
        step();
        chk_all("rst_held", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd0);
        br_taken   = 1'b0;
        inst_ready = 1'b1;
        reset_n    = 1'b1;
        step();
        chk_all("post_rst", 16'h0002, 16'h6103, 16'h0000, 1'b1, 1'b0, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
